// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, then shifts
// one byte, odd parity and stop out on device-generated clock edges and reports ack/timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack,
    output logic       o_error,
    output logic [2:0] o_dbg_state
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t           state;
    logic [INH_W-1:0] inh_cnt;
    logic [19:0]      tmo_cnt;
    logic [3:0]       edge_cnt;
    logic [7:0]       byte_q;
    logic             parity_q;
    logic             nak_q;

    logic clk_meta, sync_clk, prev_clk;
    logic data_meta, sync_data;
    logic fall_edge;
    logic tmo_hit;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_meta  <= 1'b1;
            sync_clk  <= 1'b1;
            prev_clk  <= 1'b1;
            data_meta <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            clk_meta  <= i_ps2_clk;
            sync_clk  <= clk_meta;
            prev_clk  <= sync_clk;
            data_meta <= i_ps2_data;
            sync_data <= data_meta;
        end
    end

    assign fall_edge   = prev_clk & ~sync_clk;
    assign tmo_hit     = (tmo_cnt >= TMO_LAST);
    assign o_dbg_state = state;

    // Handshake: i_start is a one-cycle request honoured only while o_busy=0; o_busy rises
    // the next cycle and falls in the single cycle o_done (with o_ack/o_error) is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            inh_cnt       <= '0;
            tmo_cnt       <= '0;
            edge_cnt      <= '0;
            byte_q        <= '0;
            parity_q      <= 1'b0;
            nak_q         <= 1'b0;
            o_ps2_clk_oe  <= 1'b0;
            o_ps2_data_oe <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_ack         <= 1'b0;
            o_error       <= 1'b0;
        end else if (i_start && !o_busy) begin
            byte_q        <= i_byte;
            parity_q      <= ~^i_byte;
            inh_cnt       <= '0;
            o_busy        <= 1'b1;
            o_ps2_clk_oe  <= 1'b1;
            o_ps2_data_oe <= 1'b0;
            o_done        <= 1'b0;
            o_ack         <= 1'b0;
            o_error       <= 1'b0;
            state         <= S_INHIBIT;
        end else begin
            case (state)
                S_IDLE: begin
                    o_ps2_clk_oe  <= 1'b0;
                    o_ps2_data_oe <= 1'b0;
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        o_ps2_data_oe <= 1'b1;
                        state         <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    o_ps2_clk_oe <= 1'b0;
                    tmo_cnt      <= '0;
                    edge_cnt     <= '0;
                    nak_q        <= 1'b0;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (tmo_hit) begin
                        o_ps2_clk_oe  <= 1'b0;
                        o_ps2_data_oe <= 1'b0;
                        o_busy        <= 1'b0;
                        o_done        <= 1'b1;
                        o_ack         <= 1'b0;
                        o_error       <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        tmo_cnt <= (tmo_cnt == 20'hFFFFF) ? tmo_cnt : tmo_cnt + 20'd1;
                        if (fall_edge) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            // edge_cnt holds the number of edges already seen, so edge n uses n-1
                            if (edge_cnt < 4'd8) begin
                                o_ps2_data_oe <= ~byte_q[edge_cnt[2:0]];
                            end else if (edge_cnt == 4'd8) begin
                                o_ps2_data_oe <= ~parity_q;
                            end else if (edge_cnt == 4'd9) begin
                                o_ps2_data_oe <= 1'b0;
                            end else begin
                                nak_q         <= sync_data;
                                o_ps2_data_oe <= 1'b0;
                                state         <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    o_ps2_clk_oe  <= 1'b0;
                    o_ps2_data_oe <= 1'b0;
                    if (tmo_hit) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_ack   <= 1'b0;
                        o_error <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= (tmo_cnt == 20'hFFFFF) ? tmo_cnt : tmo_cnt + 20'd1;
                        if (sync_clk && sync_data) begin
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            o_ack   <= ~nak_q;
                            o_error <= nak_q;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_ack   <= 1'b0;
                    o_error <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    o_ps2_clk_oe  <= 1'b0;
                    o_ps2_data_oe <= 1'b0;
                    o_busy        <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; results are
// checked by a done monitor against an expected queue, device-sampled frames against another.
module tb_ps2_host_tx;

    localparam int INH  = 6000;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       clk_oe, data_oe, busy, done, ack, error;
    logic [2:0] dbg_state;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(clk_oe | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe),
        .i_start      (start),
        .i_byte       (byte_in),
        .o_busy       (busy),
        .o_done       (done),
        .o_ack        (ack),
        .o_error      (error),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int idle_bad = 0;
    bit idle_watch = 1'b0;

    logic [1:0] exp_q[$];        // {ack, error}
    logic [9:0] exp_frame_q[$];  // bit0 = first bit sampled at a rising edge
    logic [1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got ack=%0b error=%0b, expected no done", ack, error);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_ack_error", {30'd0, ack, error}, {30'd0, mon_exp});
            end
            check("oe_released_at_done", {30'd0, clk_oe, data_oe}, 32'd0);
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (idle_watch && (clk_oe || data_oe || busy)) idle_bad++;
    end

    // ---------------- driver tasks ----------------
    task automatic run_request(input logic [7:0] b, input bit extra_start);
        int cnt;
        bit seen;
        @(negedge clk);
        start   = 1'b1;
        byte_in = b;
        @(negedge clk);
        start   = 1'b0;
        byte_in = 8'h00;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < INH + 100; i++) begin
            if (data_oe) begin
                seen = 1'b1;
                break;
            end
            if (clk_oe) cnt++;
            if (extra_start && i == 100) begin
                start   = 1'b1;
                byte_in = 8'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("request_seen", {31'd0, seen}, 32'd1);
        check("inhibit_len", cnt, INH);
        check("clk_held_at_req", {31'd0, clk_oe}, 32'd1);
        @(negedge clk);
        check("clk_released", {31'd0, clk_oe}, 32'd0);
        check("start_bit_driven", {31'd0, data_oe}, 32'd1);
    endtask

    task automatic device_clock(input int n_edges, input bit ack_low, input bit chk_frame);
        logic [9:0] frame;
        logic [9:0] e;
        frame = '0;
        repeat (2 * HALF) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack_low) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) frame[k-1] = ps2_data;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
        if (chk_frame) begin
            if (exp_frame_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_bits: got %0h, expected nothing queued", frame);
            end else begin
                e = exp_frame_q.pop_front();
                check("frame_bits", {22'd0, frame}, {22'd0, e});
            end
        end
    endtask

    task automatic kbd_send(input logic [10:0] f);
        for (int i = 0; i < 11; i++) begin
            dev_data_low = ~f[i];
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt >= target) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_arrived", {31'd0, got}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        repeat (4) @(negedge clk);
        check("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, data_oe}, 32'd0);
        check("rst_busy_done", {29'd0, busy, done, ack}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        exp_frame_q.push_back(10'h3ED);
        exp_q.push_back(2'b10);
        run_request(8'hED, 1'b0);
        device_clock(11, 1'b1, 1'b1);
        wait_done(1);

        // 0x00 -> parity 1; 0xF4 -> parity 0
        exp_frame_q.push_back(10'h300);
        exp_q.push_back(2'b10);
        run_request(8'h00, 1'b0);
        device_clock(11, 1'b1, 1'b1);
        wait_done(2);

        exp_frame_q.push_back(10'h2F4);
        exp_q.push_back(2'b10);
        run_request(8'hF4, 1'b0);
        device_clock(11, 1'b1, 1'b1);
        wait_done(3);

        // silent device: timeout measured from clock release
        exp_q.push_back(2'b01);
        run_request(8'hA5, 1'b0);
        cnt = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            if (done) break;
            cnt++;
            @(negedge clk);
        end
        check("timeout_len", cnt, TMO);
        wait_done(4);

        // device leaves data high at edge 11: 0x81 -> parity 1
        exp_frame_q.push_back(10'h381);
        exp_q.push_back(2'b01);
        run_request(8'h81, 1'b0);
        device_clock(11, 1'b0, 1'b1);
        wait_done(5);

        // second start while busy is ignored
        exp_frame_q.push_back(10'h2F4);
        exp_q.push_back(2'b10);
        run_request(8'hF4, 1'b1);
        device_clock(11, 1'b1, 1'b1);
        wait_done(6);

        // keyboard sends scan code 0x1C while idle: start 0, data, parity 0, stop 1
        idle_bad   = 0;
        idle_watch = 1'b1;
        kbd_send({1'b1, 1'b0, 8'h1C, 1'b0});
        repeat (10) @(negedge clk);
        idle_watch = 1'b0;
        check("idle_no_oe_activity", idle_bad, 0);
        check("idle_no_done", done_cnt, 6);

        // reset during edge 5 of a 0x00 transaction (data_oe = ~bit4 = 1)
        run_request(8'h00, 1'b0);
        device_clock(4, 1'b0, 1'b0);
        dev_clk_low = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_reset_data_oe", {31'd0, data_oe}, 32'd1);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_done_after_reset", done_cnt, 6);

        exp_frame_q.push_back(10'h2F4);
        exp_q.push_back(2'b10);
        run_request(8'hF4, 1'b0);
        device_clock(11, 1'b1, 1'b1);
        wait_done(7);

        repeat (20) @(negedge clk);
        check("result_queue_drained", exp_q.size(), 0);
        check("frame_queue_drained", exp_frame_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
